mem_arbiter: RTL

Two-port arbiter that shares the single CPU RAM between the CPU control/datapath port and a DMA/debug port, such as a serial program loader or a memory inspector. It sits between the requesters and the RAM address/data/write-enable lines. It sequences each RAM access as a two-cycle address/acknowledge transaction. Ties are resolved round-robin, and DMA may hold the bus for a bounded burst.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/arb_rr2.sv | 27 ++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side types: arbiter state/grant encodings and default RAM widths.
package cpu_pkg;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} arb_state_e;
  typedef enum logic {GNT_CPU, GNT_DMA} gnt_e;
endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick between CPU and DMA with a DMA lock override.
module arb_rr2
  import cpu_pkg::*;
(
  input  logic cpuReq,
  input  logic dmaReq,
  input  gnt_e lastGnt,
  input  logic lock,
  input  logic lockMax,
  output logic gntValid,
  output gnt_e gnt
);

  always_comb begin
    gntValid = cpuReq | dmaReq;
    gnt      = GNT_CPU;
    if (cpuReq && dmaReq) begin
      if (lock && !lockMax)
        gnt = GNT_DMA;
      else
        gnt = (lastGnt == GNT_DMA) ? GNT_CPU : GNT_DMA;
    end else if (dmaReq) begin
      gnt = GNT_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM between the CPU and a DMA/debug port using two-cycle
// address/acknowledge transactions with round-robin ties and bounded DMA bursts.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpuReq,
  input  logic              i_cpuWe,
  input  logic [ADDR_W-1:0] i_cpuAddr,
  input  logic [DATA_W-1:0] i_cpuData,
  input  logic              i_dmaReq,
  input  logic              i_dmaWe,
  input  logic [ADDR_W-1:0] i_dmaAddr,
  input  logic [DATA_W-1:0] i_dmaData,
  input  logic              i_dmaLock,
  output logic              o_cpuAck,
  output logic              o_dmaAck,
  output logic [DATA_W-1:0] o_cpuData,
  output logic [DATA_W-1:0] o_dmaData,
  output logic              o_cpuStall,
  output logic [ADDR_W-1:0] o_ramAddr,
  output logic [DATA_W-1:0] o_ramData,
  output logic              o_ramWe,
  output logic              o_ramOE,
  input  logic [DATA_W-1:0] i_ramData
);

  localparam int unsigned LCW = $clog2(MAX_LOCK + 1);

  arb_state_e        state;
  gnt_e              r_gnt;
  gnt_e              r_lastGnt;
  logic [LCW-1:0]    r_lockCnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_data;

  logic lockMax, burst, inAck, cpuElig, dmaElig, gntValid, driveRam;
  gnt_e gnt;

  assign lockMax = (r_lockCnt == LCW'(MAX_LOCK));
  assign burst   = i_dmaLock & ~lockMax;
  assign inAck   = (state == ACK);
  // A held req is not re-granted in its own ACK cycle, except that an
  // unexhausted DMA lock lets the DMA continue its burst back-to-back.
  assign cpuElig = i_cpuReq & ~(inAck & (r_gnt == GNT_CPU));
  assign dmaElig = i_dmaReq & ~(inAck & (r_gnt == GNT_DMA) & ~burst);

  arb_rr2 u_rr (
    .cpuReq  (cpuElig),
    .dmaReq  (dmaElig),
    .lastGnt (r_lastGnt),
    .lock    (i_dmaLock),
    .lockMax (lockMax),
    .gntValid(gntValid),
    .gnt     (gnt)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      r_gnt     <= GNT_CPU;
      r_lastGnt <= GNT_DMA;
      r_lockCnt <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_data    <= '0;
      o_cpuAck  <= 1'b0;
      o_dmaAck  <= 1'b0;
      o_cpuData <= '0;
      o_dmaData <= '0;
    end else begin
      o_cpuAck <= 1'b0;
      o_dmaAck <= 1'b0;
      if (!i_dmaLock)
        r_lockCnt <= '0;
      unique case (state)
        IDLE, ACK: begin
          if (gntValid) begin
            state     <= ACCESS;
            r_gnt     <= gnt;
            r_lastGnt <= gnt;
            if (gnt == GNT_CPU) begin
              r_addr    <= i_cpuAddr;
              r_we      <= i_cpuWe;
              r_data    <= i_cpuData;
              r_lockCnt <= '0;
            end else begin
              r_addr <= i_dmaAddr;
              r_we   <= i_dmaWe;
              r_data <= i_dmaData;
              if (i_dmaLock && !lockMax)
                r_lockCnt <= r_lockCnt + LCW'(1);
            end
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= ACK;
          if (r_gnt == GNT_CPU) begin
            o_cpuAck <= 1'b1;
            if (!r_we) o_cpuData <= i_ramData;
          end else begin
            o_dmaAck <= 1'b1;
            if (!r_we) o_dmaData <= i_ramData;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign driveRam   = (state == ACCESS);
  assign o_ramAddr  = driveRam ? r_addr : '0;
  assign o_ramData  = driveRam ? r_data : '0;
  assign o_ramWe    = driveRam & r_we & ~i_reset;
  assign o_ramOE    = driveRam & ~r_we;
  assign o_cpuStall = i_cpuReq & ~o_cpuAck;

endmodule
